// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, mid-bit sampling, valid and framing-error pulses.
// Optional build macro UART_RX_VOTACAO_EN enables 2-of-3 majority voting on every sampling decision.
module uart_rx #(
   parameter int CLOCKS_POR_BIT = 87
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       bitSerialRecebido,
   output logic [7:0] byteRecebido,
   output logic       dadosRecebidosValidos,
   output logic       erroDeEnquadramento,
   output logic       indicaRecepcao
);

   localparam logic [15:0] MEIO   = 16'((CLOCKS_POR_BIT - 1) / 2);
   localparam logic [15:0] ULTIMO = 16'(CLOCKS_POR_BIT - 1);

   typedef enum logic [2:0] {
      ESPERA           = 3'd0,
      VERIFICA_INICIO  = 3'd1,
      RECEBE_BITS      = 3'd2,
      RECEBE_BIT_FINAL = 3'd3,
      LIMPEZA          = 3'd4,
      AGUARDA_OCIOSO   = 3'd5
   } estado_t;

   estado_t     r_estado;
   logic        r_sinc1;
   logic        r_sinc2;
   logic [15:0] r_cont;
   logic [2:0]  r_indice;
   logic [7:0]  r_desloc;
   logic        w_linha;
   logic        w_amostra;

   assign w_linha = r_sinc2;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_sinc1 <= 1'b1;
         r_sinc2 <= 1'b1;
      end else begin
         r_sinc1 <= bitSerialRecebido;
         r_sinc2 <= r_sinc1;
      end
   end

`ifdef UART_RX_VOTACAO_EN
   // Votes are taken at counts N-2 and N-1; the decision at N combines them with the live sample (needs MEIO >= 2).
   logic        r_voto_a;
   logic        r_voto_b;
   logic [15:0] w_alvo;

   assign w_alvo = (r_estado == VERIFICA_INICIO) ? MEIO : ULTIMO;

   always_ff @(posedge clock) begin
      if (r_cont == w_alvo - 16'd2) r_voto_a <= w_linha;
      if (r_cont == w_alvo - 16'd1) r_voto_b <= w_linha;
   end

   assign w_amostra = (r_voto_a & r_voto_b) | (r_voto_a & w_linha) | (r_voto_b & w_linha);
`else
   assign w_amostra = w_linha;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_estado              <= ESPERA;
         r_cont                <= 16'd0;
         r_indice              <= 3'd0;
         byteRecebido          <= 8'd0;
         dadosRecebidosValidos <= 1'b0;
         erroDeEnquadramento   <= 1'b0;
         indicaRecepcao        <= 1'b0;
      end else begin
         case (r_estado)
            ESPERA: begin
               dadosRecebidosValidos <= 1'b0;
               erroDeEnquadramento   <= 1'b0;
               r_cont                <= 16'd0;
               r_indice              <= 3'd0;
               indicaRecepcao        <= 1'b0;
               if (!w_linha) begin
                  indicaRecepcao <= 1'b1;
                  r_estado       <= VERIFICA_INICIO;
               end
            end

            VERIFICA_INICIO: begin
               if (r_cont == MEIO) begin
                  r_cont <= 16'd0;
                  if (!w_amostra) begin
                     r_estado <= RECEBE_BITS;
                  end else begin
                     indicaRecepcao <= 1'b0;
                     r_estado       <= ESPERA;
                  end
               end else begin
                  r_cont <= r_cont + 16'd1;
               end
            end

            RECEBE_BITS: begin
               if (r_cont == ULTIMO) begin
                  r_cont             <= 16'd0;
                  r_desloc[r_indice] <= w_amostra;
                  if (r_indice == 3'd7) begin
                     r_indice <= 3'd0;
                     r_estado <= RECEBE_BIT_FINAL;
                  end else begin
                     r_indice <= r_indice + 3'd1;
                  end
               end else begin
                  r_cont <= r_cont + 16'd1;
               end
            end

            RECEBE_BIT_FINAL: begin
               if (r_cont == ULTIMO) begin
                  r_cont         <= 16'd0;
                  indicaRecepcao <= 1'b0;
                  if (w_amostra) begin
                     byteRecebido          <= r_desloc;
                     dadosRecebidosValidos <= 1'b1;
                     r_estado              <= LIMPEZA;
                  end else begin
                     erroDeEnquadramento <= 1'b1;
                     r_estado            <= AGUARDA_OCIOSO;
                  end
               end else begin
                  r_cont <= r_cont + 16'd1;
               end
            end

            LIMPEZA: begin
               dadosRecebidosValidos <= 1'b0;
               erroDeEnquadramento   <= 1'b0;
               r_estado              <= ESPERA;
            end

            // A break or stuck-low line must return high before a new start bit is trusted.
            AGUARDA_OCIOSO: begin
               erroDeEnquadramento <= 1'b0;
               if (w_linha) r_estado <= ESPERA;
            end

            default: begin
               dadosRecebidosValidos <= 1'b0;
               erroDeEnquadramento   <= 1'b0;
               indicaRecepcao        <= 1'b0;
               r_cont                <= 16'd0;
               r_indice              <= 3'd0;
               r_estado              <= ESPERA;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: latency, back-to-back, glitch, framing error, reset abort, voting.
module tb_uart_rx;

   localparam int CPB  = 16;
   localparam int MEIO = (CPB - 1) / 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ser = 1'b1;
   logic [7:0] byte_o;
   logic       vld_o;
   logic       err_o;
   logic       ind_o;

   int vectors     = 0;
   int miscompares = 0;

   int cyc      = 0;
   int nvalid   = 0;
   int nerr     = 0;
   int overlap  = 0;
   int wide     = 0;
   int vld_cyc  = -1;
   int ind_cnt  = 0;
   bit win      = 1'b0;
   bit prev_vld = 1'b0;
   bit prev_err = 1'b0;
   logic [7:0] rx [16];

   uart_rx #(.CLOCKS_POR_BIT(CPB)) dut (
      .clock                 (clk),
      .reset                 (rst),
      .bitSerialRecebido     (ser),
      .byteRecebido          (byte_o),
      .dadosRecebidosValidos (vld_o),
      .erroDeEnquadramento   (err_o),
      .indicaRecepcao        (ind_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (vld_o) begin
         if (nvalid < 16) rx[nvalid] = byte_o;
         nvalid  = nvalid + 1;
         vld_cyc = cyc;
      end
      if (err_o) nerr = nerr + 1;
      if (vld_o && err_o) overlap = overlap + 1;
      if ((vld_o && prev_vld) || (err_o && prev_err)) wide = wide + 1;
      if (win && ind_o) ind_cnt = ind_cnt + 1;
      prev_vld = vld_o;
      prev_err = err_o;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors = vectors + 1;
      assert (obs === exp) else begin
         miscompares = miscompares + 1;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      ser = 1'b1;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // k is the offset of the edge that samples the pin, counted from the edge that first sees the start bit.
   task automatic send_frame(input logic [7:0] d, input int stop_len, input bit stop_val,
                             input int glitch_k, input int abort_k);
      int total;
      int b;
      bit v;
      total = 9 * CPB + stop_len;
      for (int k = 0; k < total; k++) begin
         if (k == abort_k) break;
         b = k / CPB;
         if (b == 0)      v = 1'b0;
         else if (b <= 8) v = d[b-1];
         else             v = stop_val;
         ser = v ^ (k == glitch_k);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int e;
      logic [7:0] exp_vote;

      rst = 1'b1;
      ser = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_byte", 32'(byte_o), 32'h00);
      chk("reset_valid", 32'(vld_o), 32'd0);
      chk("reset_err", 32'(err_o), 32'd0);
      chk("reset_ind", 32'(ind_o), 32'd0);
      rst = 1'b0;
      idle(10);

      // 0xA5: valid pulse is registered by edge E+154 and seen by edge E+155
      e = cyc + 1;
      send_frame(8'hA5, CPB, 1'b1, -1, -1);
      idle(20);
      chk("a5_count", 32'(nvalid), 32'd1);
      chk("a5_byte", 32'(rx[0]), 32'hA5);
      chk("a5_hold", 32'(byte_o), 32'hA5);
      chk("a5_latency", 32'(vld_cyc), 32'(e + 4 + MEIO + 9 * CPB - 1));
      chk("a5_noerr", 32'(nerr), 32'd0);
      chk("a5_ind_low", 32'(ind_o), 32'd0);

      send_frame(8'h00, CPB - 1, 1'b1, -1, -1);
      send_frame(8'hFF, CPB, 1'b1, -1, -1);
      idle(20);
      chk("b2b_count", 32'(nvalid), 32'd3);
      chk("b2b_first", 32'(rx[1]), 32'h00);
      chk("b2b_second", 32'(rx[2]), 32'hFF);
      chk("b2b_noerr", 32'(nerr), 32'd0);

      ser = 1'b0;
      repeat (5) begin
         @(posedge clk);
         #1;
      end
      idle(40);
      chk("glitch_nopulse", 32'(nvalid), 32'd3);
      chk("glitch_ind_low", 32'(ind_o), 32'd0);
      send_frame(8'h3C, CPB, 1'b1, -1, -1);
      idle(20);
      chk("after_glitch_count", 32'(nvalid), 32'd4);
      chk("after_glitch_byte", 32'(rx[3]), 32'h3C);

      send_frame(8'h12, CPB, 1'b0, -1, -1);
      win = 1'b1;
      ser = 1'b0;
      repeat (39 * CPB) begin
         @(posedge clk);
         #1;
      end
      win = 1'b0;
      chk("frame_err_once", 32'(nerr), 32'd1);
      chk("frame_err_hold", 32'(byte_o), 32'h3C);
      chk("frame_err_novalid", 32'(nvalid), 32'd4);
      chk("frame_err_no_rx", 32'(ind_cnt), 32'd0);
      idle(20);
      send_frame(8'h34, CPB, 1'b1, -1, -1);
      idle(20);
      chk("after_err_count", 32'(nvalid), 32'd5);
      chk("after_err_byte", 32'(rx[4]), 32'h34);
      chk("after_err_nerr", 32'(nerr), 32'd1);

      send_frame(8'h99, CPB, 1'b1, -1, 5 * CPB + 8);
      chk("abort_ind_before", 32'(ind_o), 32'd1);
      ser = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("abort_byte", 32'(byte_o), 32'h00);
      chk("abort_valid", 32'(vld_o), 32'd0);
      chk("abort_err", 32'(err_o), 32'd0);
      chk("abort_ind", 32'(ind_o), 32'd0);
      idle(12 * CPB);
      chk("abort_nopulse", 32'(nvalid), 32'd5);
      chk("abort_noerr", 32'(nerr), 32'd1);
      send_frame(8'h7E, CPB, 1'b1, -1, -1);
      idle(20);
      chk("after_abort_count", 32'(nvalid), 32'd6);
      chk("after_abort_byte", 32'(rx[5]), 32'h7E);

`ifdef UART_RX_VOTACAO_EN
      exp_vote = 8'h55;
`else
      exp_vote = 8'h51;
`endif
      // bit 2 decision edge is E+3+MEIO+3*CPB; its live sample is the pin two edges earlier
      send_frame(8'h55, CPB, 1'b1, 1 + MEIO + 3 * CPB, -1);
      idle(20);
      chk("vote_count", 32'(nvalid), 32'd7);
      chk("vote_byte", 32'(rx[6]), 32'(exp_vote));

      chk("pulse_overlap", 32'(overlap), 32'd0);
      chk("pulse_width", 32'(wide), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver for 8N1 serial frames: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), with a fixed bit period given in clock cycles. It sits between the FPGA serial input pin and the command-decoding logic. It is the receive-side counterpart of the project's UART transmitter and uses the same bit-period parameter, so both ends match. It delivers each received byte with a one-cycle valid pulse and flags framing errors.

Parameters:
CLOCKS_POR_BIT, 87, clock cycles per serial bit; legal range 8..65535.

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
bitSerialRecebido  input  1  asynchronous serial line, idle high
byteRecebido  output  8  last correctly framed byte; held until the next good frame
dadosRecebidosValidos  output  1  one-cycle pulse when byteRecebido is updated
erroDeEnquadramento  output  1  one-cycle pulse when the stop bit is sampled as 0
indicaRecepcao  output  1  high while a frame is being received

Behaviour:
- Decided interface: one clock (clock); reset is synchronous and active-high (reset).
- Reset: state ESPERA, counters 0, all outputs 0, both synchronizer flops set to 1 (idle). Reset mid-frame aborts the frame with no pulse.
- Input synchronizer: 2 flops. Below, "linha" is the synchronizer output, which lags the pin by 2 cycles.
- Counter: 16 bits. Bit index: 3 bits. Half period MEIO = (CLOCKS_POR_BIT-1)/2, truncating.
- States:
  - ESPERA:
    - counter and index cleared, indicaRecepcao=0.
    - linha==0 -> VERIFICA_INICIO with counter=0.
  - VERIFICA_INICIO:
    - indicaRecepcao=1, counter increments.
    - At counter==MEIO: if linha==0 -> RECEBE_BITS with counter=0.
    - Otherwise it is a glitch -> ESPERA with no pulse and indicaRecepcao back to 0.
  - RECEBE_BITS:
    - counter increments to CLOCKS_POR_BIT-1, then samples linha into shift register bit [index] and resets counter to 0.
    - index<7 -> index+1, stay.
    - index==7 -> index=0, go to RECEBE_BIT_FINAL.
  - RECEBE_BIT_FINAL: at counter==CLOCKS_POR_BIT-1, sample linha.
    - Sample 1: byteRecebido<=shift register, dadosRecebidosValidos<=1, go to LIMPEZA.
    - Sample 0: erroDeEnquadramento<=1, byteRecebido unchanged, go to AGUARDA_OCIOSO.
    - indicaRecepcao<=0 in either case.
  - LIMPEZA: one cycle; clears pulses -> ESPERA.
  - AGUARDA_OCIOSO:
    - clears the error pulse.
    - stays until linha==1 (break or stuck-low line), then -> ESPERA.
  - Unused encodings -> ESPERA.
- Pulses: dadosRecebidosValidos and erroDeEnquadramento are registered, exactly 1 cycle wide, and never high together.
- Latency: valid pulse is high in cycle E + 4 + MEIO + 9*CLOCKS_POR_BIT, where E is the first cycle the pin is sampled low. For CLOCKS_POR_BIT=16 this is E+155.
- Back-to-back frames:
  - A new start bit seen in the cycle after LIMPEZA is accepted.
  - A stop bit shortened by up to MEIO cycles is still received correctly.

Optional Feature:
UART_RX_VOTACAO_EN:
- Defined: each decision (start-bit check and every data/stop sample) takes the 2-of-3 majority of linha sampled at counts N-2, N-1 and N, where N is the decision count (MEIO or CLOCKS_POR_BIT-1).
  - This needs MEIO>=2.
  - The decision cycle is unchanged, so latency is identical.
- Undefined: a single sample at the decision count; the voting registers are not instantiated.

Test Plan:
- Frame 0xA5, CLOCKS_POR_BIT=16 -> byteRecebido=0xA5; dadosRecebidosValidos high for exactly 1 cycle at E+155; erroDeEnquadramento stays 0; indicaRecepcao low afterwards.
- Back-to-back 0x00 then 0xFF, stop bit 1 cycle short -> two valid pulses with bytes 0x00 and 0xFF in order; no error pulse.
- 5-cycle low glitch on an idle line (CLOCKS_POR_BIT=16) -> no pulse; state returns to ESPERA; a following 0x3C frame is received correctly.
- Frame 0x12 with stop bit 0, line held low 40 bit times, then idle and frame 0x34 -> error pulse once; byteRecebido still holds the old value; no reception during the low period; then 0x34 is received with a valid pulse.
- reset asserted during data bit 4 of a frame -> next cycle all outputs 0; no pulse for the aborted frame; next frame 0x7E is received correctly.
- With UART_RX_VOTACAO_EN, frame 0x55 with a 1-cycle inverted glitch on the decision count of bit 2 -> byteRecebido=0x55. Without the macro the same stimulus -> 0x51.
